pipelined_block_cla_adder: RTL and testbench
============================================

# pipelined_block_cla_adder

Pipelined successor to the ripple-of-CLA-groups adder. Each GROUP_WIDTH-bit carry-lookahead group sits in its own pipeline stage, and the inter-group carry is registered between stages. Adds a per-transaction add/subtract mode and a valid/ready handshake on both sides. Sustains one result per cycle at any operand width, with latency GROUP_COUNT cycles. It is the arithmetic datapath block used behind the lab stream interfaces.

## Interface
- GROUP_WIDTH, 4: bits per CLA group; ≥1.
- GROUP_COUNT, 2: number of groups, which is also the number of pipeline stages; ≥1. Total width N = GROUP_WIDTH*GROUP_COUNT.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- sub  in  1  0: z = x + y + carry_in; 1: z = x + ~y + 1 (carry_in ignored).
- carry_in  in  1  carry into bit 0 when sub=0.
- x  in  N  operand A.
- y  in  N  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- z  out  N  sum/difference mod 2^N.
- carry_out  out  1  carry out of bit N-1. When sub=1 this is the no-borrow flag (1 when x ≥ y unsigned).
- overflow  out  1  signed overflow; present only with CLA_PIPE_OVERFLOW_EN.

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stage k (0..GROUP_COUNT-1) contains one combinational GROUP_WIDTH CLA group. It adds slice k of x and of y', where y' = sub ? ~y : y.
  - Stage 0 carry = sub ? 1 : carry_in.
  - Stage k>0 carry = the registered carry from stage k-1.
- Pipeline registers per stage boundary: valid bit, carry, already-computed low z slices, and not-yet-used high x/y' slices. Unused slices are delayed, not recomputed.
- Global advance enable: adv = ~out_valid | out_ready. in_ready = adv.
  - When adv=1, every stage register loads from the stage before it. Stage 0 loads in_valid and operands.
  - When adv=0, all stage registers hold.
- Bubbles are not collapsed. A stalled pipeline holds every slot, including empty slots.
- out_valid = valid bit of the last stage register. z and carry_out come from that register and are stable while out_valid & ~out_ready.
- Data registers may load when their valid is 0 (no gating needed). Valid registers must follow the rules above exactly.
- Reset (asynchronous, at any time, including mid-stream): all valid bits 0, all carry and data registers 0. In-flight transactions are discarded.
  - Outputs during reset: out_valid=0, z=0, carry_out=0, overflow=0.
  - in_ready=1 during reset and after release.

## Timing
- Latency: a transaction accepted at edge t shows out_valid at edge t+GROUP_COUNT when no stall occurs.
- Throughput: 1 transaction per cycle with out_ready held at 1.
- Each stall cycle (out_valid=1, out_ready=0) adds exactly one cycle to every in-flight transaction.
- Simultaneous events:
  - Accept and emit in the same cycle is legal and needs no extra storage.
  - in_valid while in_ready=0: no transfer, and the block samples no operands.
- Combinational paths: out_ready to in_ready only. There is no path from x/y/in_valid to any output.
- Critical path per stage: one GROUP_WIDTH CLA plus the y inversion in stage 0.
- GROUP_COUNT=1 degenerates to a single registered stage with latency 1.

## Configuration
- CLA_PIPE_OVERFLOW_EN defined:
  - The last stage additionally captures the carry into bit N-1.
  - overflow = carry_into_msb ^ carry_out, registered and aligned with z.
  - Reset value 0.
- Not defined: no overflow port, no extra register.

## Test plan
- Reset and idle (defaults, N=8): assert rst_n=0 mid-transfer → out_valid=0, z=0x00, carry_out=0, in_ready=1 immediately. After release, out_valid stays 0 until a new transfer.
- Single add: x=0x7F, y=0x01, carry_in=0, sub=0 accepted at edge t → at t+2 z=0x80, carry_out=0, overflow=1 (macro on).
- Subtract and carry_in ignore: x=0x05, y=0x07, sub=1, carry_in=1 → z=0xFE, carry_out=0. Next x=0x07, y=0x05, sub=1 → z=0x02, carry_out=1.
- Back-to-back stream: 256 random transfers with out_ready=1 → one result per cycle, in order, each matching a reference model, first result 2 cycles after the first accept.
- Backpressure: toggle out_ready randomly (~50%) with continuous in_valid → no loss or duplication, z stable while stalled, in_ready==(~out_valid|out_ready) every cycle.
- Geometry sweep: GROUP_WIDTH∈{1,4,8}, GROUP_COUNT∈{1,3,4}. x=all-ones, y=0, carry_in=1 → z=0, carry_out=1 after exactly GROUP_COUNT cycles.

Source files
------------

// File: rtl/pipelined_block_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_block_cla_adder; N = total operand width.
// The overflow signal exists only when CLA_PIPE_OVERFLOW_EN is defined.
interface pipelined_block_cla_adder_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic         carry_in;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;
  logic         carry_out;
`ifdef CLA_PIPE_OVERFLOW_EN
  logic         overflow;

  modport master (
    output in_valid, sub, carry_in, x, y, out_ready,
    input  in_ready, out_valid, z, carry_out, overflow
  );
  modport slave (
    input  in_valid, sub, carry_in, x, y, out_ready,
    output in_ready, out_valid, z, carry_out, overflow
  );
`else
  modport master (
    output in_valid, sub, carry_in, x, y, out_ready,
    input  in_ready, out_valid, z, carry_out
  );
  modport slave (
    input  in_valid, sub, carry_in, x, y, out_ready,
    output in_ready, out_valid, z, carry_out
  );
`endif
endinterface

// File: rtl/pipelined_block_cla_adder.sv
// Add/subtract with one CLA group per pipeline stage; CLA_PIPE_OVERFLOW_EN adds a signed overflow flag.
// Latency GROUP_COUNT cycles, 1/cycle; one global advance enable stalls every slot (bubbles included).
module pipelined_block_cla_adder #(
  parameter int GROUP_WIDTH = 4,
  parameter int GROUP_COUNT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pipelined_block_cla_adder_if.slave bus
);
  localparam int N    = GROUP_WIDTH * GROUP_COUNT;
  localparam int LAST = GROUP_COUNT - 1;

  // Returns {carry into group msb, carry out, sum}; carries are formed in lookahead form.
  function automatic logic [GROUP_WIDTH+1:0] cla_group(
    input logic [GROUP_WIDTH-1:0] a,
    input logic [GROUP_WIDTH-1:0] b,
    input logic                   c0
  );
    logic [GROUP_WIDTH-1:0] g;
    logic [GROUP_WIDTH-1:0] p;
    logic [GROUP_WIDTH:0]   c;
    logic                   term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP_WIDTH; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[GROUP_WIDTH-1], c[GROUP_WIDTH], p ^ c[GROUP_WIDTH-1:0]};
  endfunction

  logic [GROUP_COUNT-1:0] vld_q;
  logic [GROUP_COUNT-1:0] cy_q;
  logic [GROUP_COUNT-1:0] cy_d;
  logic [N-1:0]           x_q  [GROUP_COUNT];
  logic [N-1:0]           yp_q [GROUP_COUNT];
  logic [N-1:0]           z_q  [GROUP_COUNT];
  logic [N-1:0]           z_d  [GROUP_COUNT];

  logic [N-1:0]           x_s  [GROUP_COUNT];
  logic [N-1:0]           y_s  [GROUP_COUNT];
  logic [N-1:0]           z_s  [GROUP_COUNT];
  logic [GROUP_COUNT-1:0] v_s;
  logic [GROUP_COUNT-1:0] c_s;
  logic                   adv;

  assign adv = ~vld_q[LAST] | bus.out_ready;

  assign x_s[0] = bus.x;
  assign y_s[0] = bus.sub ? ~bus.y : bus.y;
  assign z_s[0] = '0;
  assign v_s[0] = bus.in_valid;
  assign c_s[0] = bus.sub | bus.carry_in;

  for (genvar k = 1; k < GROUP_COUNT; k++) begin : g_src
    assign x_s[k] = x_q[k-1];
    assign y_s[k] = yp_q[k-1];
    assign z_s[k] = z_q[k-1];
    assign v_s[k] = vld_q[k-1];
    assign c_s[k] = cy_q[k-1];
  end

`ifdef CLA_PIPE_OVERFLOW_EN
  logic cmsb_d;
  logic ovf_q;
`endif

  always_comb begin
    logic [GROUP_WIDTH+1:0] grp;
    grp  = '0;
    cy_d = '0;
`ifdef CLA_PIPE_OVERFLOW_EN
    cmsb_d = 1'b0;
`endif
    for (int k = 0; k < GROUP_COUNT; k++) begin
      grp = cla_group(x_s[k][k*GROUP_WIDTH +: GROUP_WIDTH],
                      y_s[k][k*GROUP_WIDTH +: GROUP_WIDTH], c_s[k]);
      z_d[k] = z_s[k];
      z_d[k][k*GROUP_WIDTH +: GROUP_WIDTH] = grp[GROUP_WIDTH-1:0];
      cy_d[k] = grp[GROUP_WIDTH];
`ifdef CLA_PIPE_OVERFLOW_EN
      if (k == LAST) cmsb_d = grp[GROUP_WIDTH+1];
`endif
    end
  end

  // Data slots load even when empty; only the valid bits carry meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      for (int k = 0; k < GROUP_COUNT; k++) begin
        x_q[k]  <= '0;
        yp_q[k] <= '0;
        z_q[k]  <= '0;
      end
    end else if (adv) begin
      vld_q <= v_s;
      cy_q  <= cy_d;
      for (int k = 0; k < GROUP_COUNT; k++) begin
        x_q[k]  <= x_s[k];
        yp_q[k] <= y_s[k];
        z_q[k]  <= z_d[k];
      end
    end
  end

`ifdef CLA_PIPE_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= cmsb_d ^ cy_d[LAST];
    end
  end
  assign bus.overflow = ovf_q;
`endif

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[LAST];
  assign bus.z         = z_q[LAST];
  assign bus.carry_out = cy_q[LAST];
endmodule

// File: tb/tb_pipelined_block_cla_adder.sv
// Scoreboard bench: driver pushes reference-model results on accept, monitor pops on emit.
`timescale 1ns/1ps
module tb_pipelined_block_cla_adder;
  localparam int GW = 4;
  localparam int GC = 2;
  localparam int N  = GW * GC;

  typedef struct {
    logic [N-1:0] z;
    logic         c;
    logic         v;
    int           acc_cyc;
    int           acc_stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_block_cla_adder_if #(.N(N)) bus();
  pipelined_block_cla_adder #(.GROUP_WIDTH(GW), .GROUP_COUNT(GC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stalls = 0;
  exp_t exp_q[$];
  exp_t drv_exp;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic s, input logic c);
    exp_t   e;
    longint ux, uy, sx, sy, full, r, modv, half;
    modv = longint'(1) << N;
    half = modv / 2;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= half) ? ux - modv : ux;
    sy = (uy >= half) ? uy - modv : uy;
    if (s) begin
      full = ux - uy;
      e.c  = (ux >= uy);
      r    = sx - sy;
    end else begin
      full = ux + uy + longint'(c);
      e.c  = (full >= modv);
      r    = sx + sy + longint'(c);
    end
    if (full < 0) full = full + modv;
    e.z = N'(full % modv);
    e.v = (r < -half) || (r >= half);
    e.acc_cyc = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [N-1:0] z, input logic c, input logic v);
    exp_t e;
    e.z = z; e.c = c; e.v = v; e.acc_cyc = 0; e.acc_stall = 0;
    return e;
  endfunction

  logic [N-1:0] prev_z;
  logic         prev_c;
  logic         prev_stall = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      check("in_ready_rule", bus.in_ready, (!bus.out_valid) || bus.out_ready);
      if (prev_stall) begin
        check("stall_vld", bus.out_valid, 1);
        check("stall_z", bus.z, prev_z);
        check("stall_c", bus.carry_out, prev_c);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got z=%0h want no result", bus.z);
        end else begin
          e = exp_q.pop_front();
          check("z", bus.z, e.z);
          check("carry_out", bus.carry_out, e.c);
`ifdef CLA_PIPE_OVERFLOW_EN
          check("overflow", bus.overflow, e.v);
`endif
          check("latency", cyc - e.acc_cyc, GC + (stalls - e.acc_stall));
        end
      end
      if (bus.out_valid && !bus.out_ready) stalls++;
      if (bus.in_valid && bus.in_ready) begin
        e = drv_exp;
        e.acc_cyc = cyc;
        e.acc_stall = stalls;
        exp_q.push_back(e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_z = bus.z;
      prev_c = bus.carry_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                      input logic c, input exp_t e, input bit rand_ready);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.x = x; bus.y = y; bus.sub = s; bus.carry_in = c;
    drv_exp = e;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!bus.in_ready && guard < 1000) begin
      guard++;
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send_rand(input bit rand_ready);
    logic [N-1:0] rx, ry;
    logic rs, rc;
    rx = N'($urandom); ry = N'($urandom);
    rs = 1'($urandom); rc = 1'($urandom);
    send(rx, ry, rs, rc, model(rx, ry, rs, rc), rand_ready);
  endtask

  logic sweep_go = 1'b0;
  int   sweep_done = 0;

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    localparam int SC = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int SN = SW * SC;
    pipelined_block_cla_adder_if #(.N(SN)) sb();
    pipelined_block_cla_adder #(.GROUP_WIDTH(SW), .GROUP_COUNT(SC)) sdut (
      .clk(clk), .rst_n(rst_n), .bus(sb)
    );
    initial begin
      int lat;
      logic [SN-1:0] ones;
      sb.in_valid = 1'b0; sb.sub = 1'b0; sb.carry_in = 1'b0;
      sb.x = '0; sb.y = '0; sb.out_ready = 1'b1;
      wait (sweep_go);
      ones = '1;
      @(posedge clk); #1;
      sb.in_valid = 1'b1; sb.x = ones; sb.y = '0; sb.carry_in = 1'b1;
      @(posedge clk); #1;
      sb.in_valid = 1'b0;
      lat = 1;
      while (!sb.out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("sweep%0d_latency", g), lat, SC);
      check($sformatf("sweep%0d_z", g), sb.z, 0);
      check($sformatf("sweep%0d_carry", g), sb.carry_out, 1);
      sweep_done++;
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.sub = 1'b0; bus.carry_in = 1'b0;
    bus.x = '0; bus.y = '0; bus.out_ready = 1'b1;
    drv_exp = mk('0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_z", bus.z, 0);
    check("rst_carry", bus.carry_out, 0);
    check("rst_in_ready", bus.in_ready, 1);
`ifdef CLA_PIPE_OVERFLOW_EN
    check("rst_overflow", bus.overflow, 0);
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_out_valid", bus.out_valid, 0);
    end

    // directed cases with hand-derived results
    send(8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1), 0);
    send(8'h05, 8'h07, 1'b1, 1'b1, mk(8'hFE, 1'b0, 1'b0), 0);
    send(8'h07, 8'h05, 1'b1, 1'b0, mk(8'h02, 1'b1, 1'b0), 0);
    idle();
    drain();

    repeat (256) send_rand(0);
    idle();
    drain();

    repeat (256) send_rand(1);
    idle();
    drain();

    // reset in the middle of a stream with in_valid still high
    repeat (4) send_rand(0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_z", bus.z, 0);
    check("midrst_carry", bus.carry_out, 0);
    check("midrst_in_ready", bus.in_ready, 1);
`ifdef CLA_PIPE_OVERFLOW_EN
    check("midrst_overflow", bus.overflow, 0);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_out_valid", bus.out_valid, 0);
    end

    sweep_go = 1'b1;
    for (int i = 0; i < 100 && sweep_done < 3; i++) @(negedge clk);
    check("sweep_finished", sweep_done, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
